gate_bank_checker: RTL and testbench

Sequential self-test engine for the seven-function two-input gate bank (AND, OR, NOT-a, XOR, XNOR, NAND, NOR). It drives the bank's `a`/`b` inputs through all four input vectors, lets each vector settle, samples the seven outputs and compares them against internally computed expected values. It reports a pass flag, a per-function error mask and a per-vector fail mask. It sits on the stimulus side of the gate bank, replacing the hand-written stimulus sequence with a synthesizable, repeatable checker.

---
 rtl/gate_bank_checker.sv | 129 ++++++++++++
 tb/tb_gate_bank_checker.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/gate_bank_checker.sv
`default_nettype none
// ============================================================================
//  Module   : gate_bank_checker
//  Brief    : Self-test sequencer for the 7-function two-input gate bank.
//             Walks ab = 00..11 and compares sampled outputs with the truth table.
//  Revision : 1.0 - initial release
// ============================================================================
module gate_bank_checker #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [6:0] gate_in,
  output logic       a_drv,
  output logic       b_drv,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [6:0] err_mask,
  output logic [3:0] fail_vec
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRIVE  = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [7:0] c_settle_last = 8'(SETTLE_CYCLES - 1);

  state_t     r_state;
  logic [1:0] r_v;
  logic [7:0] r_cnt;
  logic       r_a;
  logic       r_b;
  logic       r_busy;
  logic       r_done;
  logic       r_pass;
  logic [6:0] r_err;
  logic [3:0] r_fail;

  logic       w_a;
  logic       w_b;
  logic [1:0] w_v_next;
  logic [6:0] w_exp;
  logic [6:0] w_mm;

  // Expected outputs follow the vector index, not the registered drive pins.
  assign w_a      = r_v[1];
  assign w_b      = r_v[0];
  assign w_v_next = r_v + 2'd1;
  assign w_exp    = {~(w_a | w_b), ~(w_a & w_b), ~(w_a ^ w_b), w_a ^ w_b,
                     ~w_a, w_a | w_b, w_a & w_b};
  assign w_mm     = gate_in ^ w_exp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_v     <= 2'd0;
      r_cnt   <= 8'd0;
      r_a     <= 1'b0;
      r_b     <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_err   <= 7'd0;
      r_fail  <= 4'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_DRIVE;
            r_v     <= 2'd0;
            r_cnt   <= 8'd0;
            r_a     <= 1'b0;
            r_b     <= 1'b0;
            r_busy  <= 1'b1;
            r_pass  <= 1'b0;
            r_err   <= 7'd0;
            r_fail  <= 4'd0;
          end
        end
        S_DRIVE: begin
          r_cnt <= r_cnt + 8'd1;
          if (r_cnt == c_settle_last) begin
            r_state <= S_SAMPLE;
          end
        end
        S_SAMPLE: begin
          r_err       <= r_err | w_mm;
          r_fail[r_v] <= |w_mm;
          if (r_v == 2'd3) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= ((r_err | w_mm) == 7'd0);
          end else begin
            r_state <= S_DRIVE;
            r_v     <= w_v_next;
            r_cnt   <= 8'd0;
            r_a     <= w_v_next[1];
            r_b     <= w_v_next[0];
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_a     <= 1'b0;
          r_b     <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign a_drv    = r_a;
  assign b_drv    = r_b;
  assign busy     = r_busy;
  assign done     = r_done;
  assign pass     = r_pass;
  assign err_mask = r_err;
  assign fail_vec = r_fail;

endmodule
`default_nettype wire

// File: tb/tb_gate_bank_checker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gate_bank_checker
//  Brief    : Directed bench for gate_bank_checker (default and 1-cycle settle).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_gate_bank_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [6:0] gate_in;
  logic       a_drv, b_drv, busy, done, pass;
  logic [6:0] err_mask;
  logic [3:0] fail_vec;

  logic       rst1_n;
  logic       start1;
  logic [6:0] gate_in1;
  logic       a1, b1, busy1, done1, pass1;
  logic [6:0] err1;
  logic [3:0] fail1;

  int  mode;
  logic glitch;
  int  n_checks = 0;
  int  n_pass = 0;
  int  done_cnt = 0;

  always #5 clk = ~clk;

  gate_bank_checker dut (
    .clk(clk), .rst_n(rst_n), .start(start), .gate_in(gate_in),
    .a_drv(a_drv), .b_drv(b_drv), .busy(busy), .done(done), .pass(pass),
    .err_mask(err_mask), .fail_vec(fail_vec)
  );

  gate_bank_checker #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst1_n), .start(start1), .gate_in(gate_in1),
    .a_drv(a1), .b_drv(b1), .busy(busy1), .done(done1), .pass(pass1),
    .err_mask(err1), .fail_vec(fail1)
  );

  // Gate bank model: 0 healthy, 1 XOR stuck-at-0, 2 NAND/NOR swapped.
  function automatic logic [6:0] bank(input logic a, input logic b, input int m);
    logic [6:0] g;
    g = {~(a | b), ~(a & b), ~(a ^ b), a ^ b, ~a, a | b, a & b};
    if (m == 1) g[3] = 1'b0;
    if (m == 2) g = {g[5], g[6], g[4:0]};
    return g;
  endfunction

  always_comb begin
    gate_in  = bank(a_drv, b_drv, mode);
    gate_in1 = bank(a1, b1, 0) ^ {7{glitch}};
  end

  always @(negedge clk) if (done) done_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Full run on the default instance; edge k counts from the accepting edge.
  task automatic run(input int m, input logic exp_pass, input logic [6:0] exp_err,
                     input logic [3:0] exp_fail, input bit extra_starts);
    mode = m;
    done_cnt = 0;
    start = 1'b1;
    tick;
    start = 1'b0;
    check("busy_rise", {31'd0, busy}, 32'd1);
    check("ab_v0", {30'd0, a_drv, b_drv}, 32'd0);
    for (int k = 1; k <= 14; k++) begin
      start = extra_starts && (k == 5 || k == 13);
      tick;
      if (k == 3)  check("ab_v1", {30'd0, a_drv, b_drv}, 32'd1);
      if (k == 6)  check("ab_v2", {30'd0, a_drv, b_drv}, 32'd2);
      if (k == 9)  check("ab_v3", {30'd0, a_drv, b_drv}, 32'd3);
      if (k == 11) check("done_early", {30'd0, busy, done}, 32'd2);
      if (k == 12) begin
        check("done_at_12", {30'd0, busy, done}, 32'd1);
        check("pass", {31'd0, pass}, {31'd0, exp_pass});
        check("err_mask", {25'd0, err_mask}, {25'd0, exp_err});
        check("fail_vec", {28'd0, fail_vec}, {28'd0, exp_fail});
      end
      if (k == 13) check("idle_ab", {29'd0, a_drv, b_drv, done}, 32'd0);
    end
    start = 1'b0;
    check("busy_after", {31'd0, busy}, 32'd0);
    check("done_pulses", done_cnt, 32'd1);
    check("results_hold", {20'd0, pass, err_mask, fail_vec}, {20'd0, exp_pass, exp_err, exp_fail});
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; rst1_n = 1'b0; start = 1'b0; start1 = 1'b0;
    mode = 0; glitch = 1'b0;
    tick; tick;
    check("rst_outputs", {15'd0, a_drv, b_drv, busy, done, pass, err_mask, fail_vec}, 32'd0);
    check("rst_outputs1", {15'd0, a1, b1, busy1, done1, pass1, err1, fail1}, 32'd0);
    rst_n = 1'b1; rst1_n = 1'b1;
    tick;

    run(0, 1'b1, 7'b0000000, 4'b0000, 1'b0);
    run(1, 1'b0, 7'b0001000, 4'b0110, 1'b0);
    run(2, 1'b0, 7'b1100000, 4'b0110, 1'b0);
    run(0, 1'b1, 7'b0000000, 4'b0000, 1'b1);

    // Restart must clear results from a failing run.
    run(1, 1'b0, 7'b0001000, 4'b0110, 1'b0);
    mode = 0;
    start = 1'b1;
    tick;
    start = 1'b0;
    check("start_clears", {20'd0, pass, err_mask, fail_vec}, 32'd0);
    for (int k = 1; k <= 7; k++) tick;
    check("mid_run_v2", {29'd0, a_drv, b_drv, busy}, 32'd5);
    rst_n = 1'b0;
    #1;
    check("async_rst", {15'd0, a_drv, b_drv, busy, done, pass, err_mask, fail_vec}, 32'd0);
    tick;
    rst_n = 1'b1;
    tick;
    run(0, 1'b1, 7'b0000000, 4'b0000, 1'b0);

    // One-cycle settle: each vector is DRIVE (glitched) then SAMPLE (clean).
    start1 = 1'b1;
    tick;
    start1 = 1'b0;
    glitch = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick;
      glitch = (k % 2 == 0) && (k < 8);
      if (k == 2) check("s1_ab_v1", {30'd0, a1, b1}, 32'd1);
      if (k == 7) check("s1_done_early", {30'd0, busy1, done1}, 32'd2);
      if (k == 8) begin
        check("s1_done_at_8", {30'd0, busy1, done1}, 32'd1);
        check("s1_results", {20'd0, pass1, err1, fail1}, 32'h800);
      end
      if (k == 9) check("s1_done_drop", {31'd0, done1}, 32'd0);
    end
    glitch = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
